branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- Sits directly downstream of the 2-bit branch predictor.
- Captures each requested branch address together with the registered prediction the predictor returns one cycle later, and holds the pair in an in-order queue until the execute stage resolves the branch.
- On resolution, emits a one-cycle update (address, actual outcome) back to the predictor table, flags mispredictions, and keeps saturating statistics counters.

Parameters:
- DEPTH, 8, queue entries (power of two, >=2).
- ADDR_W, 10, branch address width (matches predictor table index).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous, active-high reset.
- branch_req  in  1  branch lookup request issued to predictor this cycle.
- branch_address  in  ADDR_W  address of requested branch.
- prediction  in  1  registered predictor output (valid the cycle after branch_req).
- res_valid  in  1  in-order resolution strobe from execute.
- res_taken  in  1  actual outcome (1 = taken), qualified by res_valid.
- flush  in  1  pipeline flush; discards all in-flight entries.
- upd_valid  out  1  one-cycle update strobe to predictor.
- upd_address  out  ADDR_W  table index to update.
- upd_taken  out  1  actual outcome for update.
- mispredict  out  1  one-cycle pulse with upd_valid when stored prediction != res_taken.
- occupancy  out  $clog2(DEPTH+1)  entries currently queued.
- full  out  1  occupancy == DEPTH.
- empty  out  1  occupancy == 0.
- overflow_err  out  1  sticky: push attempted while full.
- underflow_err  out  1  sticky: res_valid while empty.
- resolved_count  out  CNT_W  saturating count of resolved branches.
- mispredict_count  out  CNT_W  saturating count of mispredictions.

Behaviour:
- Reset (async, rst_b=1): queue empty, pending stage cleared, all outputs 0 except empty=1; counters and sticky flags cleared. Reset mid-operation discards everything immediately.
- Capture stage: branch_req sampled at edge N registers {branch_address, pend_valid=1}.
- At edge N+1, if pend_valid, prediction is sampled and {addr, pred} is pushed. occupancy reflects the push after edge N+1.
- Back-to-back requests every cycle are supported.
- Push while full and no same-cycle pop: entry dropped, overflow_err set (sticky until reset), queue unchanged.
- Push while full with same-cycle pop: push accepted, occupancy unchanged.
- Resolution: res_valid sampled at edge M pops the head entry.
- At edge M the registered outputs load, valid for exactly one cycle after M:
  - upd_valid=1, upd_address=head.addr, upd_taken=res_taken;
  - mispredict = (head.pred != res_taken).
- Otherwise upd_valid and mispredict are 0. upd_address and upd_taken hold their last value.
- res_valid while empty: ignored, no update, underflow_err set (sticky).
  - This includes the case where a push lands on the same edge: a pop never sees the entry written that edge.
- Simultaneous push and pop on non-empty queue: both performed, occupancy unchanged.
- Counters:
  - resolved_count increments on each valid pop.
  - mispredict_count increments when mispredict is generated.
  - Both saturate at all-ones; no wrap.
- Pointers wrap modulo DEPTH; occupancy is tracked with an explicit counter, never derived from pointer difference.
- Flush (synchronous, highest priority): at the sampling edge, clears queue, pointers, occupancy and pend_valid. Same-cycle branch_req and res_valid are discarded, with no update, no error and no count. Counters and sticky flags are retained.

Decomposition:
- Package branch_pkg holds:
  - BP_ADDR_W constant;
  - typedef bp_entry_t struct {addr[ADDR_W], pred};
  - an RQ_DEPTH default constant.
- One natural sub-module: bp_sync_fifo, a parameterised entry FIFO with push, pop, flush, full, empty and count.
- The top-level block adds the capture stage, update register, error logic and counters.

Test Plan:
- Single branch: req addr 0x155 at cycle 0, prediction=1 at cycle 1, res_valid res_taken=0 at cycle 4 -> cycle 5: upd_valid=1, upd_address=0x155, upd_taken=0, mispredict=1; resolved_count=1, mispredict_count=1.
- Fill: 8 consecutive reqs (addr 0..7), then a 9th -> full=1, occupancy=8, overflow_err=1. Eight resolutions then return addresses 0..7 in order.
- Full with simultaneous push and pop -> push accepted, occupancy stays 8, overflow_err stays 0.
- res_valid with empty queue, including a push landing on the same edge -> no upd_valid, underflow_err=1, occupancy=1 afterwards.
- Flush with 5 queued entries and res_valid and branch_req asserted the same cycle -> occupancy=0, no upd_valid, counters unchanged, next req enqueued normally.
- Saturation with CNT_W=4: 20 mispredicted resolutions -> both counters hold 15. Async reset asserted mid-stream -> all outputs 0, empty=1, immediately.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and entry type for the branch resolve queue.
package branch_pkg;

  // Predictor table index width; also the default branch address width.
  localparam int BP_ADDR_W = 10;

  // Default number of in-flight branches held awaiting resolution.
  localparam int RQ_DEPTH = 8;

  // One queued branch: its table index and the prediction it was given.
  typedef struct packed {
    logic [BP_ADDR_W-1:0] addr;
    logic                 pred;
  } bp_entry_t;

endpackage

// File: rtl/bp_sync_fifo.sv
// In-order entry FIFO with synchronous flush and an explicit occupancy
// counter. The caller qualifies push/pop; this block performs them as asked.
module bp_sync_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = RQ_DEPTH,
  parameter int WIDTH = BP_ADDR_W + 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;
  logic [CNT_W-1:0] count_next_s;

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    count_next_s = count_r;
    if (push && !pop) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (!push && pop) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(DEPTH));
      empty_r <= (count_next_s == {CNT_W{1'b0}});
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/branch_resolve_queue.sv
// Holds {address, prediction} for each in-flight branch until execute
// resolves it, then issues a one-cycle predictor update, flags
// mispredictions and keeps saturating statistics.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH  = RQ_DEPTH,
  parameter int ADDR_W = BP_ADDR_W,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic              prediction,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic              flush,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_address,
  output logic              upd_taken,
  output logic              mispredict,
  output logic [OCC_W-1:0]  occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic [CNT_W-1:0]  resolved_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int ENT_W = ADDR_W + 1;

  logic              pend_valid_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic              upd_valid_r;
  logic [ADDR_W-1:0] upd_address_r;
  logic              upd_taken_r;
  logic              mispredict_r;
  logic              overflow_r;
  logic              underflow_r;
  logic [CNT_W-1:0]  resolved_cnt_r;
  logic [CNT_W-1:0]  mispred_cnt_r;

  logic              push_s;
  logic              pop_s;
  logic              mis_s;
  logic              ovf_s;
  logic              unf_s;
  logic [ENT_W-1:0]  push_entry_s;
  logic [ENT_W-1:0]  head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [OCC_W-1:0]  fifo_count_s;

  // Qualify push/pop; flush wins over everything, and a pop only sees
  // entries that were present before this edge.
  always_comb begin
    pop_s        = res_valid & ~fifo_empty_s & ~flush;
    push_s       = pend_valid_r & (~fifo_full_s | pop_s) & ~flush;
    push_entry_s = {pend_addr_r, prediction};
    mis_s        = pop_s & (head_s[0] != res_taken);
    ovf_s        = pend_valid_r & fifo_full_s & ~pop_s & ~flush;
    unf_s        = res_valid & fifo_empty_s & ~flush;
  end

  bp_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .flush (flush),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Capture stage: remember the requested address until its prediction arrives.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      pend_valid_r <= 1'b0;
      pend_addr_r  <= {ADDR_W{1'b0}};
    end else if (flush) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= branch_req;
      if (branch_req) begin
        pend_addr_r <= branch_address;
      end
    end
  end

  // Update register: strobes pulse for one cycle, payload holds its last value.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      upd_valid_r   <= 1'b0;
      upd_address_r <= {ADDR_W{1'b0}};
      upd_taken_r   <= 1'b0;
      mispredict_r  <= 1'b0;
    end else begin
      upd_valid_r  <= pop_s;
      mispredict_r <= mis_s;
      if (pop_s) begin
        upd_address_r <= head_s[ENT_W-1:1];
        upd_taken_r   <= res_taken;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_s) begin
        overflow_r <= 1'b1;
      end
      if (unf_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Saturating statistics; they stop at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      resolved_cnt_r <= {CNT_W{1'b0}};
      mispred_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (pop_s && (resolved_cnt_r != {CNT_W{1'b1}})) begin
        resolved_cnt_r <= resolved_cnt_r + CNT_W'(1);
      end
      if (mis_s && (mispred_cnt_r != {CNT_W{1'b1}})) begin
        mispred_cnt_r <= mispred_cnt_r + CNT_W'(1);
      end
    end
  end

  assign upd_valid        = upd_valid_r;
  assign upd_address      = upd_address_r;
  assign upd_taken        = upd_taken_r;
  assign mispredict       = mispredict_r;
  assign occupancy        = fifo_count_s;
  assign full             = fifo_full_s;
  assign empty            = fifo_empty_s;
  assign overflow_err     = overflow_r;
  assign underflow_err    = underflow_r;
  assign resolved_count   = resolved_cnt_r;
  assign mispredict_count = mispred_cnt_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a default instance plus a
// CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_branch_resolve_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b;
  logic       branch_req;
  logic [9:0] branch_address;
  logic       prediction;
  logic       res_valid;
  logic       res_taken;
  logic       flush;

  logic        upd_valid, upd_taken, mispredict, full, empty, overflow_err, underflow_err;
  logic [9:0]  upd_address;
  logic [3:0]  occupancy;
  logic [15:0] resolved_count, mispredict_count;

  logic        s_upd_valid, s_upd_taken, s_mispredict, s_full, s_empty, s_overflow_err, s_underflow_err;
  logic [9:0]  s_upd_address;
  logic [3:0]  s_occupancy;
  logic [3:0]  s_resolved_count, s_mispredict_count;

  int total = 0;
  int bad   = 0;

  branch_resolve_queue dut (
    .clk(clk), .rst_b(rst_b), .branch_req(branch_req), .branch_address(branch_address),
    .prediction(prediction), .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_address(upd_address), .upd_taken(upd_taken),
    .mispredict(mispredict), .occupancy(occupancy), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .resolved_count(resolved_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_queue #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_b(rst_b), .branch_req(branch_req), .branch_address(branch_address),
    .prediction(prediction), .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(s_upd_valid), .upd_address(s_upd_address), .upd_taken(s_upd_taken),
    .mispredict(s_mispredict), .occupancy(s_occupancy), .full(s_full), .empty(s_empty),
    .overflow_err(s_overflow_err), .underflow_err(s_underflow_err),
    .resolved_count(s_resolved_count), .mispredict_count(s_mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_b = 1'b1;
    #2;
    rst_b = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
    chk({tag, "_upd_address"}, 32'(upd_address), 32'd0);
    chk({tag, "_upd_taken"}, 32'(upd_taken), 32'd0);
    chk({tag, "_mispredict"}, 32'(mispredict), 32'd0);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_overflow"}, 32'(overflow_err), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow_err), 32'd0);
    chk({tag, "_resolved"}, 32'(resolved_count), 32'd0);
    chk({tag, "_mispred_cnt"}, 32'(mispredict_count), 32'd0);
    chk({tag, "_s_upd_valid"}, 32'(s_upd_valid), 32'd0);
    chk({tag, "_s_upd_address"}, 32'(s_upd_address), 32'd0);
    chk({tag, "_s_upd_taken"}, 32'(s_upd_taken), 32'd0);
    chk({tag, "_s_mispredict"}, 32'(s_mispredict), 32'd0);
    chk({tag, "_s_occupancy"}, 32'(s_occupancy), 32'd0);
    chk({tag, "_s_full"}, 32'(s_full), 32'd0);
    chk({tag, "_s_empty"}, 32'(s_empty), 32'd1);
    chk({tag, "_s_overflow"}, 32'(s_overflow_err), 32'd0);
    chk({tag, "_s_underflow"}, 32'(s_underflow_err), 32'd0);
    chk({tag, "_s_resolved"}, 32'(s_resolved_count), 32'd0);
    chk({tag, "_s_mispred_cnt"}, 32'(s_mispredict_count), 32'd0);
  endtask

  initial begin
    rst_b          = 1'b1;
    branch_req     = 1'b0;
    branch_address = 10'd0;
    prediction     = 1'b0;
    res_valid      = 1'b0;
    res_taken      = 1'b0;
    flush          = 1'b0;
    #12;
    chk_reset_state("reset");
    rst_b = 1'b0;
    tick();

    // Single branch, predicted taken, resolved not-taken.
    branch_req = 1'b1; branch_address = 10'h155;
    tick();
    branch_req = 1'b0; prediction = 1'b1;
    tick();
    chk("t1_occ_after_push", 32'(occupancy), 32'd1);
    chk("t1_not_empty", 32'(empty), 32'd0);
    prediction = 1'b0;
    tick();
    tick();
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    chk("t1_upd_valid", 32'(upd_valid), 32'd1);
    chk("t1_upd_address", 32'(upd_address), 32'h155);
    chk("t1_upd_taken", 32'(upd_taken), 32'd0);
    chk("t1_mispredict", 32'(mispredict), 32'd1);
    chk("t1_resolved", 32'(resolved_count), 32'd1);
    chk("t1_mispred_cnt", 32'(mispredict_count), 32'd1);
    chk("t1_empty", 32'(empty), 32'd1);
    res_valid = 1'b0;
    tick();
    chk("t1_upd_valid_drop", 32'(upd_valid), 32'd0);
    chk("t1_mispredict_drop", 32'(mispredict), 32'd0);
    chk("t1_upd_address_hold", 32'(upd_address), 32'h155);

    // Fill with addresses 0..7 (odd ones predicted taken), then a ninth.
    for (int i = 0; i < 9; i++) begin
      branch_req = 1'b1; branch_address = 10'(i);
      prediction = (i > 0) ? 1'((i - 1) % 2) : 1'b0;
      tick();
    end
    branch_req = 1'b0; prediction = 1'b0;
    tick();
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_occupancy", 32'(occupancy), 32'd8);
    chk("t2_overflow", 32'(overflow_err), 32'd1);
    for (int i = 0; i < 8; i++) begin
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      chk("t2_drain_valid", 32'(upd_valid), 32'd1);
      chk("t2_drain_addr", 32'(upd_address), 32'(i));
      chk("t2_drain_mispredict", 32'(mispredict), 32'((i % 2) == 0));
    end
    res_valid = 1'b0;
    tick();
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_resolved", 32'(resolved_count), 32'd9);
    chk("t2_mispred_cnt", 32'(mispredict_count), 32'd5);

    // Full queue with a push and pop on the same edge.
    reset_pulse();
    chk("t3_overflow_cleared", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      branch_req = 1'b1; branch_address = 10'(16 + i); prediction = 1'b0;
      tick();
    end
    branch_req = 1'b0;
    tick();
    chk("t3_full_before", 32'(full), 32'd1);
    chk("t3_overflow_before", 32'(overflow_err), 32'd0);
    branch_req = 1'b1; branch_address = 10'h3ff;
    tick();
    branch_req = 1'b0; prediction = 1'b1; res_valid = 1'b1; res_taken = 1'b0;
    tick();
    chk("t3_occupancy", 32'(occupancy), 32'd8);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_overflow", 32'(overflow_err), 32'd0);
    chk("t3_upd_address", 32'(upd_address), 32'h10);
    chk("t3_mispredict", 32'(mispredict), 32'd0);
    prediction = 1'b0; res_taken = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_drain_addr", 32'(upd_address), (i < 7) ? 32'(17 + i) : 32'h3ff);
      chk("t3_drain_mispredict", 32'(mispredict), 32'(i < 7));
    end
    res_valid = 1'b0;
    tick();
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_resolved", 32'(resolved_count), 32'd9);
    chk("t3_mispred_cnt", 32'(mispredict_count), 32'd7);

    // Resolution while empty, with a push landing on the same edge.
    branch_req = 1'b1; branch_address = 10'h2a5;
    tick();
    branch_req = 1'b0; prediction = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
    tick();
    chk("t4_no_update", 32'(upd_valid), 32'd0);
    chk("t4_underflow", 32'(underflow_err), 32'd1);
    chk("t4_occupancy", 32'(occupancy), 32'd1);
    chk("t4_resolved", 32'(resolved_count), 32'd9);
    res_taken = 1'b0;
    tick();
    chk("t4_pop_valid", 32'(upd_valid), 32'd1);
    chk("t4_pop_addr", 32'(upd_address), 32'h2a5);
    chk("t4_pop_mispredict", 32'(mispredict), 32'd0);
    chk("t4_resolved_after", 32'(resolved_count), 32'd10);
    res_valid = 1'b0;

    // Flush with five queued entries plus same-cycle request and resolution.
    for (int i = 0; i < 5; i++) begin
      branch_req = 1'b1; branch_address = 10'(64 + i); prediction = 1'b1;
      tick();
    end
    branch_req = 1'b0;
    tick();
    chk("t5_occ_before", 32'(occupancy), 32'd5);
    flush = 1'b1; branch_req = 1'b1; branch_address = 10'h155; res_valid = 1'b1; res_taken = 1'b0;
    tick();
    chk("t5_occupancy", 32'(occupancy), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_no_update", 32'(upd_valid), 32'd0);
    chk("t5_resolved", 32'(resolved_count), 32'd10);
    chk("t5_mispred_cnt", 32'(mispredict_count), 32'd7);
    chk("t5_underflow_kept", 32'(underflow_err), 32'd1);
    flush = 1'b0; branch_req = 1'b0; res_valid = 1'b0; prediction = 1'b1;
    tick();
    chk("t5_req_discarded", 32'(occupancy), 32'd0);
    branch_req = 1'b1; branch_address = 10'h0ab;
    tick();
    branch_req = 1'b0; prediction = 1'b1;
    tick();
    chk("t5_new_push", 32'(occupancy), 32'd1);
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    chk("t5_new_addr", 32'(upd_address), 32'h0ab);
    chk("t5_new_mispredict", 32'(mispredict), 32'd0);
    chk("t5_new_resolved", 32'(resolved_count), 32'd11);
    res_valid = 1'b0;
    tick();

    // Twenty mispredicted resolutions: the 4-bit counters must stick at 15.
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      branch_req = 1'b1; branch_address = 10'(i);
      tick();
      branch_req = 1'b0; prediction = 1'b1;
      tick();
      res_valid = 1'b1; res_taken = 1'b0;
      tick();
      res_valid = 1'b0;
    end
    chk("t6_s_resolved_sat", 32'(s_resolved_count), 32'd15);
    chk("t6_s_mispred_sat", 32'(s_mispredict_count), 32'd15);
    chk("t6_resolved", 32'(resolved_count), 32'd20);
    chk("t6_mispred_cnt", 32'(mispredict_count), 32'd20);

    // Asynchronous reset in the middle of an update cycle.
    branch_req = 1'b1; branch_address = 10'h1c3;
    tick();
    branch_req = 1'b0; prediction = 1'b0;
    tick();
    res_valid = 1'b1; res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("t7_upd_before_reset", 32'(upd_valid), 32'd1);
    rst_b = 1'b1;
    #1;
    chk_reset_state("t7_async");
    rst_b = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
